// File: rtl/fft_ram_sched_if.sv
// Signal bundle between the FFT RAM sequencer (master) and the RAM, butterfly
// and twiddle ROM side (slave).
interface fft_ram_sched_if #(
  parameter int AWL = 8
);
  localparam int SW = $clog2(AWL) + 1;

  // start is a level request that is taken only while the sequencer is idle;
  // there is no ready: busy covers the run and done pulses once at its end.
  logic           start;
  logic           busy;
  logic           done;
  logic           dbg_dump;
  logic           en_a;
  logic           en_b;
  logic           we_a;
  logic           we_b;
  logic [AWL-1:0] addr_a;
  logic [AWL-1:0] addr_b;
  logic [AWL-2:0] tw_addr;
  logic           bf_valid;
  logic [SW-1:0]  stage;
  logic [1:0]     fsm_state;

  modport master (
    input  start,
    output busy, done, dbg_dump,
    output en_a, en_b, we_a, we_b, addr_a, addr_b,
    output tw_addr, bf_valid, stage, fsm_state
  );

  modport slave (
    output start,
    input  busy, done, dbg_dump,
    input  en_a, en_b, we_a, we_b, addr_a, addr_b,
    input  tw_addr, bf_valid, stage, fsm_state
  );
endinterface

// File: rtl/fft_ram_sched.sv
// In-place radix-2 DIT FFT RAM sequencer: reads on even slots, write-backs D
// cycles later on odd slots, stage after stage until all log2(N) are done.
module fft_ram_sched #(
  parameter int AWL    = 8,
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  fft_ram_sched_if.master bus
);
  localparam int N  = 1 << AWL;
  localparam int D  = RD_LAT + BF_LAT;
  localparam int P  = N - 1 + D;
  localparam int SW = $clog2(AWL) + 1;
  localparam int TW = $clog2(P);
  localparam logic [SW-1:0]  LAST_STAGE = SW'(AWL - 1);
  localparam logic [TW-1:0]  LAST_T     = TW'(P - 1);
  localparam logic [AWL-2:0] LAST_K     = '1;

  if ((D % 2) == 0) begin : g_even_d
    $error("fft_ram_sched: RD_LAT + BF_LAT must be odd");
  end
  if (AWL < 2) begin : g_small_awl
    $error("fft_ram_sched: AWL must be at least 2");
  end
  if (RD_LAT < 1) begin : g_small_rd_lat
    $error("fft_ram_sched: RD_LAT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t         state;
  logic [SW-1:0]  s;
  logic [AWL-2:0] k;
  logic [TW-1:0]  t;
  logic           busy_r;
  logic           done_r;
  logic           en_r;
  logic           we_r;
  logic [AWL-1:0] addr_a_r;
  logic [AWL-1:0] addr_b_r;

  // Write-back delay line (D deep) and read-to-butterfly strobe line.
  logic [D-1:0]   wv;
  logic [AWL-1:0] wa [D];
  logic [AWL-1:0] wb [D];
  logic [RD_LAT:0] tv;
  logic [AWL-2:0] tt [RD_LAT+1];

  logic           issue_rd;
  logic [SW-1:0]  rd_stage;
  logic [AWL-2:0] rd_k;
  logic [AWL-1:0] kx;
  logic [AWL-1:0] span;
  logic [AWL-1:0] jv;
  logic [AWL-1:0] gv;
  logic [AWL-1:0] rd_a;
  logic [AWL-1:0] rd_b;
  logic [AWL-2:0] rd_tw;

  // A read goes out next cycle on start, on every even in-stage slot, and
  // right after the last write-back of a stage that is not the final one.
  always_comb begin
    issue_rd = 1'b0;
    rd_stage = s;
    rd_k     = k;
    case (state)
      IDLE: begin
        issue_rd = bus.start;
        rd_stage = '0;
        rd_k     = '0;
      end
      RUN: issue_rd = t[0];
      DRAIN: begin
        issue_rd = (t == LAST_T) && (s != LAST_STAGE);
        rd_stage = s + SW'(1);
        rd_k     = '0;
      end
      default: issue_rd = 1'b0;
    endcase
  end

  // tw = (k mod span) << (AWL-1-s) equals k << (AWL-1-s) kept to AWL-1 bits.
  always_comb begin
    kx    = {1'b0, rd_k};
    span  = AWL'(1) << rd_stage;
    jv    = kx & (span - AWL'(1));
    gv    = kx >> rd_stage;
    rd_a  = ((gv << rd_stage) << 1) | jv;
    rd_b  = rd_a + span;
    rd_tw = rd_k << (LAST_STAGE - rd_stage);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      s        <= '0;
      k        <= '0;
      t        <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      en_r     <= 1'b0;
      we_r     <= 1'b0;
      addr_a_r <= '0;
      addr_b_r <= '0;
      wv       <= '0;
      tv       <= '0;
      for (int i = 0; i < D; i++) begin
        wa[i] <= '0;
        wb[i] <= '0;
      end
      for (int i = 0; i <= RD_LAT; i++) begin
        tt[i] <= '0;
      end
    end else begin
      wv[0] <= 1'b0;
      for (int i = 1; i < D; i++) begin
        wv[i] <= wv[i-1];
        wa[i] <= wa[i-1];
        wb[i] <= wb[i-1];
      end
      tv[0] <= 1'b0;
      tt[0] <= '0;
      for (int i = 1; i <= RD_LAT; i++) begin
        tv[i] <= tv[i-1];
        tt[i] <= tt[i-1];
      end

      done_r   <= 1'b0;
      en_r     <= 1'b0;
      we_r     <= 1'b0;
      addr_a_r <= '0;
      addr_b_r <= '0;

      if (wv[D-1]) begin
        en_r     <= 1'b1;
        we_r     <= 1'b1;
        addr_a_r <= wa[D-1];
        addr_b_r <= wb[D-1];
      end

      if (issue_rd) begin
        en_r     <= 1'b1;
        we_r     <= 1'b0;
        addr_a_r <= rd_a;
        addr_b_r <= rd_b;
        wv[0]    <= 1'b1;
        wa[0]    <= rd_a;
        wb[0]    <= rd_b;
        tv[0]    <= 1'b1;
        tt[0]    <= rd_tw;
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= RUN;
            s      <= '0;
            k      <= (AWL-1)'(1);
            t      <= '0;
            busy_r <= 1'b1;
          end
        end
        RUN: begin
          t <= t + TW'(1);
          if (t[0]) begin
            k <= k + (AWL-1)'(1);
            if (k == LAST_K) state <= DRAIN;
          end
        end
        DRAIN: begin
          t <= t + TW'(1);
          if (t == LAST_T) begin
            if (s == LAST_STAGE) begin
              state  <= DONE;
              done_r <= 1'b1;
              busy_r <= 1'b0;
              s      <= '0;
            end else begin
              state <= RUN;
              s     <= s + SW'(1);
              k     <= (AWL-1)'(1);
              t     <= '0;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.dbg_dump  = done_r;
  assign bus.en_a      = en_r;
  assign bus.en_b      = en_r;
  assign bus.we_a      = we_r;
  assign bus.we_b      = we_r;
  assign bus.addr_a    = addr_a_r;
  assign bus.addr_b    = addr_b_r;
  assign bus.tw_addr   = tt[RD_LAT];
  assign bus.bf_valid  = tv[RD_LAT];
  assign bus.stage     = s;
  assign bus.fsm_state = state;
endmodule

// File: tb/tb_fft_ram_sched.sv
// Bench for fft_ram_sched: a timing model fills an expected queue per run and
// every cycle's packed outputs are compared against it.
module tb_fft_ram_sched;
  localparam int W = 36;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_ram_sched_if #(.AWL(3)) bus0 ();
  fft_ram_sched_if #(.AWL(4)) bus1 ();

  fft_ram_sched #(.AWL(3), .RD_LAT(1), .BF_LAT(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  fft_ram_sched #(.AWL(4), .RD_LAT(2), .BF_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic [W-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [W-1:0] obs0();
    return {bus0.busy, bus0.done, bus0.dbg_dump, bus0.en_a, bus0.en_b, bus0.we_a, bus0.we_b,
            bus0.bf_valid, 8'(bus0.addr_a), 8'(bus0.addr_b), 8'(bus0.tw_addr), 4'(bus0.stage)};
  endfunction

  function automatic logic [W-1:0] obs1();
    return {bus1.busy, bus1.done, bus1.dbg_dump, bus1.en_a, bus1.en_b, bus1.we_a, bus1.we_b,
            bus1.bf_valid, 8'(bus1.addr_a), 8'(bus1.addr_b), 8'(bus1.tw_addr), 4'(bus1.stage)};
  endfunction

  // Expected outputs for cycle c of a run (c = 0 is the first read slot).
  function automatic logic [W-1:0] model(int awl, int rd, int bf, int c);
    int n, d, p, s, t, span, kk, tr, a, b, tw;
    logic busy, en, we, bfv;
    n = 1 << awl;
    d = rd + bf;
    p = n - 1 + d;
    if (c < 0 || c > awl * p) return '0;
    if (c == awl * p) return {1'b0, 1'b1, 1'b1, 33'd0};
    s = c / p;
    t = c % p;
    span = 1 << s;
    busy = 1'b1; en = 1'b0; we = 1'b0; bfv = 1'b0;
    a = 0; b = 0; tw = 0; kk = -1;
    if (t % 2 == 0 && t <= n - 2) begin
      kk = t / 2; en = 1'b1;
    end else if (t % 2 == 1 && t >= d && t <= n - 2 + d) begin
      kk = (t - d) / 2; en = 1'b1; we = 1'b1;
    end
    if (kk >= 0) begin
      a = (kk / span) * 2 * span + (kk % span);
      b = a + span;
    end
    tr = t - rd;
    if (tr >= 0 && tr % 2 == 0 && tr <= n - 2) begin
      bfv = 1'b1;
      tw = ((tr / 2) % span) * ((n / 2) / span);
    end
    return {busy, 1'b0, 1'b0, en, en, we, we, bfv, 8'(a), 8'(b), 8'(tw), 4'(s)};
  endfunction

  task automatic test_reset();
    logic [W-1:0] o, e;
    rst = 1'b1;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < 5; c++) begin
      rst = (c < 4);
      bus0.start = (c < 4) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus1.start = (c < 4) ? 1'($urandom_range(0, 1)) : 1'b0;
      exp_q.push_back('0);
      exp_q.push_back('0);
      @(negedge clk);
      o = obs0(); e = exp_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL reset_dut0 cycle %0d: got %h expected %h", c, o, e);
      end
      o = obs1(); e = exp_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL reset_dut1 cycle %0d: got %h expected %h", c, o, e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_full_run();
    logic [W-1:0] o, e;
    int bfcnt[3], last_wr[3], first_rd[3];
    int done_c;
    for (int i = 0; i < 3; i++) begin
      bfcnt[i] = 0; last_wr[i] = -1; first_rd[i] = -1;
    end
    done_c = -1;
    bus0.start = 1'b1;
    for (int c = 0; c < 33; c++) exp_q.push_back(model(3, 1, 2, c));
    @(posedge clk);
    #1;
    bus0.start = 1'b0;
    for (int c = 0; c < 33; c++) begin
      @(negedge clk);
      o = obs0(); e = exp_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL full_run cycle %0d: got %h expected %h", c, o, e);
      end
      if (bus0.busy && bus0.stage < 3) begin
        if (bus0.bf_valid) bfcnt[bus0.stage]++;
        if (bus0.en_a && bus0.we_a) last_wr[bus0.stage] = c;
        if (bus0.en_a && !bus0.we_a && first_rd[bus0.stage] < 0) first_rd[bus0.stage] = c;
      end
      if (bus0.done && done_c < 0) done_c = c;
      @(posedge clk);
      #1;
    end
    for (int s = 0; s < 3; s++) begin
      vectors++;
      if (bfcnt[s] !== 4) begin
        miscompares++;
        $display("FAIL bf_valid_count stage %0d: got %0d expected 4", s, bfcnt[s]);
      end
    end
    for (int s = 0; s < 2; s++) begin
      vectors++;
      if (first_rd[s+1] - last_wr[s] !== 1) begin
        miscompares++;
        $display("FAIL raw_order stage %0d: got gap %0d expected 1", s, first_rd[s+1] - last_wr[s]);
      end
    end
    vectors++;
    if (done_c !== 30) begin
      miscompares++;
      $display("FAIL done_cycle: got %0d expected 30", done_c);
    end
  endtask

  task automatic test_start_ignored();
    logic [W-1:0] o, e;
    bus0.start = 1'b1;
    for (int c = 0; c < 65; c++) exp_q.push_back((c <= 30) ? model(3, 1, 2, c) : model(3, 1, 2, c - 32));
    @(posedge clk);
    #1;
    for (int c = 0; c < 65; c++) begin
      bus0.start = (c == 5 || c == 30 || c == 31);
      @(negedge clk);
      o = obs0(); e = exp_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL start_ignored cycle %0d: got %h expected %h", c, o, e);
      end
      @(posedge clk);
      #1;
    end
    bus0.start = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] o, e;
    bus0.start = 1'b1;
    for (int c = 0; c < 20; c++) exp_q.push_back((c <= 13) ? model(3, 1, 2, c) : W'(0));
    @(posedge clk);
    #1;
    bus0.start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      rst = (c == 13);
      @(negedge clk);
      o = obs0(); e = exp_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL reset_mid cycle %0d: got %h expected %h", c, o, e);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    bus0.start = 1'b1;
    for (int c = 0; c < 33; c++) exp_q.push_back(model(3, 1, 2, c));
    @(posedge clk);
    #1;
    bus0.start = 1'b0;
    for (int c = 0; c < 33; c++) begin
      @(negedge clk);
      o = obs0(); e = exp_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL rerun_after_reset cycle %0d: got %h expected %h", c, o, e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] o, e;
    int done_c;
    done_c = -1;
    bus1.start = 1'b1;
    for (int c = 0; c < 149; c++) exp_q.push_back((c <= 72) ? model(4, 2, 1, c) : model(4, 2, 1, c - 74));
    @(posedge clk);
    #1;
    for (int c = 0; c < 149; c++) begin
      bus1.start = (c < 140);
      @(negedge clk);
      o = obs1(); e = exp_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL back_to_back cycle %0d: got %h expected %h", c, o, e);
      end
      if (bus1.done && done_c < 0) done_c = c;
      @(posedge clk);
      #1;
    end
    bus1.start = 1'b0;
    vectors++;
    if (done_c !== 72) begin
      miscompares++;
      $display("FAIL done_cycle_awl4: got %0d expected 72", done_c);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_run();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL queue_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
